// File: rtl/simd_alu_pkg.sv
// simd_alu_pkg: shared types, field positions and helpers for the
// pipelined SIMD post-adder ALU and its lane slices.
package simd_alu_pkg;

    typedef enum logic [2:0] {
        OP_SUM,
        OP_XOR,
        OP_AND,
        OP_OR,
        OP_ILLEGAL
    } op_e;

    localparam int ALU_SEL_LO = 0;
    localparam int ALU_SEL_HI = 1;
    localparam int ALU_GRP_LO = 2;
    localparam int ALU_GRP_HI = 3;

    localparam int OPM_LOGIC_OR = 3;
    localparam int OPM_ZFB      = 4;

    // Carry injected into the Z combine at a group boundary; every arithmetic
    // form is expressed as (~)Z + T with an optional final inversion, so no +1.
    localparam logic ZCIN_CTRL = 1'b0;

    function automatic int lanes_per_group(input int k, input int lanes);
        return lanes >> k;
    endfunction

    function automatic op_e decode_op(input logic [3:0] alumode, input logic or_sel);
        op_e op;
        case (alumode[ALU_GRP_HI:ALU_GRP_LO])
            2'b00:   op = OP_SUM;
            2'b01:   op = OP_XOR;
            2'b11:   op = or_sel ? OP_OR : OP_AND;
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/simd_alu_pipelined_param_lane.sv
// simd_alu_lane: one LANE_W slice of the SIMD ALU. Purely combinational.
// T = W+X+Y+t_cin keeps a 2-bit carry; the Z combine keeps a 1-bit carry.
module simd_alu_lane
    import simd_alu_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0] w,
    input  logic [LANE_W-1:0] x,
    input  logic [LANE_W-1:0] y,
    input  logic [LANE_W-1:0] z,
    input  op_e               op,
    input  logic              z_inv,
    input  logic              s_inv,
    input  logic [1:0]        t_cin,
    input  logic              z_cin,
    output logic [LANE_W-1:0] s,
    output logic [1:0]        t_cout,
    output logic              z_cout
);

    logic [LANE_W+1:0] t_sum;
    logic [LANE_W-1:0] z_eff;
    logic [LANE_W:0]   z_sum;

    // Three-operand sum, then the (optionally inverted) Z combine and op select
    always_comb begin
        t_sum  = {2'b00, w} + {2'b00, x} + {2'b00, y} + {{LANE_W{1'b0}}, t_cin};
        t_cout = t_sum[LANE_W+1:LANE_W];
        z_eff  = z_inv ? ~z : z;
        z_sum  = {1'b0, z_eff} + {1'b0, t_sum[LANE_W-1:0]} + {{LANE_W{1'b0}}, z_cin};
        s      = '0;
        z_cout = 1'b0;
        case (op)
            OP_SUM: begin
                s      = s_inv ? ~z_sum[LANE_W-1:0] : z_sum[LANE_W-1:0];
                z_cout = z_sum[LANE_W];
            end
            OP_XOR:  s = x ^ z;
            OP_AND:  s = x & z;
            OP_OR:   s = x | z;
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/simd_alu_pipelined_param.sv
// simd_alu_pipelined_param: two-stage SIMD post-adder ALU with P feedback.
// Optional output pattern_det is built when SIMD_ALU_PATTERN_DETECT_EN is defined.
module simd_alu_pipelined_param
    import simd_alu_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int SIMD_W = 2,
    parameter logic [LANES*LANE_W-1:0] PATTERN = '0,
    parameter logic [LANES*LANE_W-1:0] PMASK   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [3:0]              ALUMODE,
    input  logic [8:0]              OPMODE,
    input  logic [SIMD_W-1:0]       USE_SIMD,
    input  logic                    CIN,
    input  logic [LANES*LANE_W-1:0] W,
    input  logic [LANES*LANE_W-1:0] X,
    input  logic [LANES*LANE_W-1:0] Y,
    input  logic [LANES*LANE_W-1:0] Z,
`ifdef SIMD_ALU_PATTERN_DETECT_EN
    output logic                    pattern_det,
`endif
    output logic [LANES*LANE_W-1:0] P,
    output logic                    out_valid,
    output logic [LANES-1:0]        CARRYOUT,
    output logic                    mode_err
);

    localparam int DW         = LANES * LANE_W;
    localparam int LOG2_LANES = $clog2(LANES);

    logic [DW-1:0]     s1_w, s1_x, s1_y, s1_z;
    logic              s1_cin, s1_valid, s1_logic_or, s1_zfb;
    logic [3:0]        s1_alumode;
    logic [SIMD_W-1:0] s1_use_simd;

    int            k_int;
    int            grp;
    logic          k_err;
    op_e           op;
    logic          z_inv, s_inv, err_next;
    logic [DW-1:0] z_src, p_comb, p_next;
    logic [LANES-1:0] co_comb, co_next;
    logic          unused_bits;

    // Stage 1: operand and control capture
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_w        <= '0;
            s1_x        <= '0;
            s1_y        <= '0;
            s1_z        <= '0;
            s1_cin      <= 1'b0;
            s1_alumode  <= '0;
            s1_logic_or <= 1'b0;
            s1_zfb      <= 1'b0;
            s1_use_simd <= '0;
            s1_valid    <= 1'b0;
        end else if (ce) begin
            s1_w        <= W;
            s1_x        <= X;
            s1_y        <= Y;
            s1_z        <= Z;
            s1_cin      <= CIN;
            s1_alumode  <= ALUMODE;
            s1_logic_or <= OPMODE[OPM_LOGIC_OR];
            s1_zfb      <= OPMODE[OPM_ZFB];
            s1_use_simd <= USE_SIMD;
            s1_valid    <= in_valid;
        end
    end

    // Decode op, partition size and Z source from the stage-1 registers
    always_comb begin
        k_int    = int'(s1_use_simd);
        k_err    = k_int > LOG2_LANES;
        grp      = lanes_per_group(k_int, LANES);
        op       = decode_op(s1_alumode, s1_logic_or);
        z_inv    = s1_alumode[ALU_SEL_LO];
        s_inv    = s1_alumode[ALU_SEL_HI];
        z_src    = s1_zfb ? P : s1_z;
        err_next = k_err || (op == OP_ILLEGAL);
        p_next   = err_next ? '0 : p_comb;
        co_next  = err_next ? '0 : co_comb;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [1:0]        t_cin, t_cout;
        logic              z_cin, z_cout;
        logic [LANE_W-1:0] s;

        if (i == 0) begin : g_lo
            assign t_cin = (k_int == 0) ? {1'b0, s1_cin} : 2'b00;
            assign z_cin = ZCIN_CTRL;
        end else begin : g_hi
            logic bnd;
            assign bnd   = k_err || ((i & (grp - 1)) == 0);
            assign t_cin = bnd ? 2'b00 : g_lane[i-1].t_cout;
            assign z_cin = bnd ? ZCIN_CTRL : g_lane[i-1].z_cout;
        end

        simd_alu_lane #(.LANE_W(LANE_W)) u_lane (
            .w      (s1_w[i*LANE_W +: LANE_W]),
            .x      (s1_x[i*LANE_W +: LANE_W]),
            .y      (s1_y[i*LANE_W +: LANE_W]),
            .z      (z_src[i*LANE_W +: LANE_W]),
            .op     (op),
            .z_inv  (z_inv),
            .s_inv  (s_inv),
            .t_cin  (t_cin),
            .z_cin  (z_cin),
            .s      (s),
            .t_cout (t_cout),
            .z_cout (z_cout)
        );

        assign p_comb[i*LANE_W +: LANE_W] = s;
        assign co_comb[i]                 = z_cout;
    end

    // Stage 2: result registers; bubbles hold P and CARRYOUT
    always_ff @(posedge clk) begin
        if (reset) begin
            P         <= '0;
            CARRYOUT  <= '0;
            mode_err  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                P        <= p_next;
                CARRYOUT <= co_next;
                mode_err <= err_next;
            end else begin
                mode_err <= 1'b0;
            end
        end
    end

`ifdef SIMD_ALU_PATTERN_DETECT_EN
    // Pattern match on the result being registered, masked by PMASK
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_det <= 1'b0;
        end else if (ce) begin
            pattern_det <= s1_valid && (((p_next ^ PATTERN) & ~PMASK) == '0);
        end
    end

    assign unused_bits = ^{OPMODE[8:5], OPMODE[2:0], g_lane[LANES-1].t_cout};
`else
    assign unused_bits = ^{OPMODE[8:5], OPMODE[2:0], g_lane[LANES-1].t_cout, PATTERN, PMASK};
`endif

endmodule

// File: tb/tb_simd_alu_pipelined_param.sv
// tb_simd_alu_pipelined_param: scoreboard bench for the pipelined SIMD ALU.
// Checks pattern_det as well when SIMD_ALU_PATTERN_DETECT_EN is defined.
module tb_simd_alu_pipelined_param;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, CIN;
    logic [3:0]  ALUMODE;
    logic [8:0]  OPMODE;
    logic [1:0]  USE_SIMD;
    logic [31:0] W, X, Y, Z;
    logic [31:0] P;
    logic        out_valid, mode_err;
    logic [3:0]  CARRYOUT;
`ifdef SIMD_ALU_PATTERN_DETECT_EN
    logic        pattern_det;
`endif

    typedef struct {
        logic [31:0] p;
        logic [3:0]  co;
        logic        err;
        logic        pd;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   vec_id = 0;

    simd_alu_pipelined_param #(
        .LANE_W  (8),
        .LANES   (4),
        .SIMD_W  (2),
        .PATTERN (32'h0000_0100),
        .PMASK   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .ALUMODE   (ALUMODE),
        .OPMODE    (OPMODE),
        .USE_SIMD  (USE_SIMD),
        .CIN       (CIN),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
`ifdef SIMD_ALU_PATTERN_DETECT_EN
        .pattern_det (pattern_det),
`endif
        .P         (P),
        .out_valid (out_valid),
        .CARRYOUT  (CARRYOUT),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] alumode, input logic [8:0] opmode,
                                 input logic [1:0] k, input logic cin,
                                 input logic [31:0] w, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] z,
                                 input logic [31:0] exp_p, input logic [3:0] exp_co,
                                 input logic exp_err, input bit expect_out);
        exp_t e;
        @(negedge clk);
        ce       = 1'b1;
        in_valid = 1'b1;
        ALUMODE  = alumode;
        OPMODE   = opmode;
        USE_SIMD = k;
        CIN      = cin;
        W        = w;
        X        = x;
        Y        = y;
        Z        = z;
        vec_id++;
        if (expect_out) begin
            e.p   = exp_p;
            e.co  = exp_co;
            e.err = exp_err;
            e.pd  = (exp_p == 32'h0000_0100);
            e.id  = vec_id;
            sb_q.push_back(e);
        end
    endtask

    task automatic drainPipeline();
        @(negedge clk);
        in_valid = 1'b0;
        ce       = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        checkOutput("drain_empty", sb_q.size(), 0);
    endtask

    // Monitor: pop and compare whenever an enabled edge presents a valid result
    initial begin
        logic ce_s, rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            ce_s  = ce;
            rst_s = reset;
            #1;
            if (!rst_s && ce_s && out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: got P=%h with out_valid=1, expected no output", P);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput($sformatf("P#%0d", e.id), P, e.p);
                    checkOutput($sformatf("CARRYOUT#%0d", e.id), CARRYOUT, e.co);
                    checkOutput($sformatf("mode_err#%0d", e.id), mode_err, e.err);
`ifdef SIMD_ALU_PATTERN_DETECT_EN
                    checkOutput($sformatf("pattern_det#%0d", e.id), pattern_det, e.pd);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; CIN = 1'b0;
        ALUMODE = '0; OPMODE = '0; USE_SIMD = '0;
        W = '0; X = '0; Y = '0; Z = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_P", P, 0);
        checkOutput("reset_CARRYOUT", CARRYOUT, 0);
        checkOutput("reset_mode_err", mode_err, 0);
`ifdef SIMD_ALU_PATTERN_DETECT_EN
        checkOutput("reset_pattern_det", pattern_det, 0);
`endif
        reset = 1'b0;

        $display("[TB] directed arithmetic and logic vectors");
        applyStimulus(4'b0000, 9'h000, 2'd0, 1'b1, 32'h1, 32'h2, 32'h3, 32'hFA, 32'h0000_0101, 4'b0001, 1'b0, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd2, 1'b1, 32'h0101_0101, 32'h0, 32'h0, 32'hFF01_FF01, 32'h0002_0002, 4'b1010, 1'b0, 1'b1);
        applyStimulus(4'b0011, 9'h000, 2'd0, 1'b0, 32'h3, 32'h0, 32'h0, 32'd10, 32'h0000_0007, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1100, 9'h008, 2'd1, 1'b1, 32'h1234_5678, 32'hF0, 32'h0, 32'h0F, 32'h0000_00FF, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0100, 9'h000, 2'd0, 1'b0, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1100, 9'h000, 2'd0, 1'b0, 32'h0, 32'hF0F0_F0F0, 32'h0, 32'hFF00_FF00, 32'hF000_F000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0001, 9'h000, 2'd0, 1'b0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0000_0004, 4'b1111, 1'b0, 1'b1);
        applyStimulus(4'b0010, 9'h000, 2'd0, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd1, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0000_FFFF, 32'h0000_0000, 4'b0011, 1'b0, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd0, 1'b0, 32'hFF, 32'hFF, 32'hFF, 32'h0, 32'h0000_02FD, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd1, 1'b0, 32'hFF00, 32'hFF00, 32'hFF00, 32'h0, 32'h0000_FD00, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd0, 1'b0, 32'h3, 32'h0, 32'h0, 32'hFD, 32'h0000_0100, 4'b0001, 1'b0, 1'b1);
        applyStimulus(4'b1000, 9'h000, 2'd0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h3, 32'h0, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd3, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1);
        drainPipeline();

        $display("[TB] accumulation through Z=P feedback, bubble and ce hold");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++)
            applyStimulus(4'b0000, 9'h010, 2'd0, 1'b0, 32'h5, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'(5 * i), 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bubble_out_valid", out_valid, 0);
        checkOutput("bubble_hold_P", P, 32'd20);
`ifdef SIMD_ALU_PATTERN_DETECT_EN
        checkOutput("bubble_pattern_det", pattern_det, 0);
`endif
        ce = 1'b0;
        in_valid = 1'b1;
        W = 32'h77;
        OPMODE = 9'h000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ce_hold_P", P, 32'd20);
            checkOutput("ce_hold_out_valid", out_valid, 0);
        end
        ce = 1'b1;
        in_valid = 1'b0;
        drainPipeline();

        $display("[TB] reset with both stages valid");
        applyStimulus(4'b0000, 9'h000, 2'd0, 1'b0, 32'h11, 32'h0, 32'h0, 32'h0, 32'h0000_0011, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 9'h000, 2'd0, 1'b0, 32'h22, 32'h0, 32'h0, 32'h0, 32'h0000_0022, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        ce = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_P", P, 0);
        checkOutput("midreset_CARRYOUT", CARRYOUT, 0);
        reset = 1'b0;
        ce = 1'b1;
        applyStimulus(4'b0000, 9'h000, 2'd0, 1'b0, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0000_0033, 4'b0000, 1'b0, 1'b1);
        drainPipeline();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
